alu_control_unit: RTL and testbench

Registered, handshaked successor to the combinational ALU decoder. Decodes `alu_operation` and `funct` (plus an immediate-logic selector) into a widened ALU control word. It also owns issue sequencing for the multi-cycle multiply/divide unit (MDU), including the HI/LO read interlock. It sits between the main decoder and the execute stage, adding one pipeline register.

---
 rtl/alu_ctrl_if.sv | 30 +++
 rtl/alu_control_unit.sv | 151 +++++++++++++++
 tb/tb_alu_control_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_if.sv
// Decode request/response bundle between the main decoder and alu_control_unit,
// including the multiply/divide issue and status lines.
interface alu_ctrl_if #(
  parameter int CTRL_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        funct;
  logic [1:0]        alu_operation;
  logic [1:0]        imm_sel;
  logic              out_valid;
  logic [CTRL_W-1:0] alu_control;
  logic              illegal;
  logic              md_start;
  logic [1:0]        md_op;
  logic              md_busy;
  logic              md_done;

  modport master (
    output in_valid, funct, alu_operation, imm_sel,
    input  in_ready, out_valid, alu_control, illegal,
    input  md_start, md_op, md_busy, md_done
  );

  modport slave (
    input  in_valid, funct, alu_operation, imm_sel,
    output in_ready, out_valid, alu_control, illegal,
    output md_start, md_op, md_busy, md_done
  );
endinterface

// File: rtl/alu_control_unit.sv
// Registered ALU control decoder with multiply/divide issue sequencing.
// Optional macro ALU_MDU_EN compiles in MDU decode, busy FSM and HI/LO interlock.
module alu_control_unit #(
  parameter int CTRL_W    = 4,
  parameter int MD_CYCLES = 32
) (
  input logic         clk,
  input logic         reset,
  alu_ctrl_if.slave   bus
);
  logic [3:0] dec_code;
  logic       dec_ill;
  logic       dec_mdu;
  logic       fire;

  always_comb begin
    dec_code = 4'b1111;
    dec_ill  = 1'b1;
    dec_mdu  = 1'b0;
    case (bus.alu_operation)
      2'b00: begin dec_code = 4'b0010; dec_ill = 1'b0; end
      2'b01: begin dec_code = 4'b0110; dec_ill = 1'b0; end
      2'b11: begin
        dec_ill = 1'b0;
        case (bus.imm_sel)
          2'b00:   dec_code = 4'b0000;
          2'b01:   dec_code = 4'b0001;
          2'b10:   dec_code = 4'b0011;
          default: dec_code = 4'b0111;
        endcase
      end
      default: begin
        dec_ill = 1'b0;
        case (bus.funct)
          6'b100000, 6'b100001: dec_code = 4'b0010;
          6'b100010, 6'b100011: dec_code = 4'b0110;
          6'b100100:            dec_code = 4'b0000;
          6'b100101:            dec_code = 4'b0001;
          6'b100110:            dec_code = 4'b0011;
          6'b100111:            dec_code = 4'b0100;
          6'b101010:            dec_code = 4'b0111;
          6'b101011:            dec_code = 4'b0101;
          6'b000000:            dec_code = 4'b1000;
          6'b000010:            dec_code = 4'b1001;
          6'b000011:            dec_code = 4'b1010;
`ifdef ALU_MDU_EN
          6'b010000:            dec_code = 4'b1100;
          6'b010010:            dec_code = 4'b1101;
          6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
            dec_code = 4'b1110;
            dec_mdu  = 1'b1;
          end
`endif
          default: begin
            dec_code = 4'b1111;
            dec_ill  = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign fire = bus.in_valid && bus.in_ready;

  // Stage p1: registered decode result
  logic              vld_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic              ill_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      ill_p1  <= 1'b0;
    end else begin
      vld_p1 <= fire;
      if (fire) begin
        ctrl_p1 <= CTRL_W'(dec_code);
        ill_p1  <= dec_ill;
      end
    end
  end

  assign bus.out_valid   = vld_p1;
  assign bus.alu_control = ctrl_p1;
  assign bus.illegal     = ill_p1;

`ifdef ALU_MDU_EN
  localparam int CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);

  typedef enum logic {IDLE, RUN} md_state_t;

  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             start_p1, start_nxt;
  logic [1:0]       op_p1, op_nxt;
  logic             hilo_hazard;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      start_p1 <= 1'b0;
      op_p1    <= 2'b00;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      start_p1 <= start_nxt;
      op_p1    <= op_nxt;
    end
  end

  // A new MDU op accepted in the done cycle reloads the counter with no bubble.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start_nxt = 1'b0;
    op_nxt    = op_p1;
    case (state)
      RUN: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: ;
    endcase
    if (fire && dec_mdu) begin
      state_nxt = RUN;
      cnt_nxt   = CNT_LOAD;
      start_nxt = 1'b1;
      op_nxt    = bus.funct[1:0];
    end
  end

  assign hilo_hazard = (bus.funct[5:2] == 4'b0110) || (bus.funct == 6'b010000) ||
                       (bus.funct == 6'b010010);

  assign bus.md_busy  = (state == RUN);
  assign bus.md_done  = (state == RUN) && (cnt == '0);
  assign bus.md_start = start_p1;
  assign bus.md_op    = op_p1;
  assign bus.in_ready = !(bus.md_busy && !bus.md_done && hilo_hazard &&
                          (bus.alu_operation == 2'b10));
`else
  assign bus.md_busy  = 1'b0;
  assign bus.md_done  = 1'b0;
  assign bus.md_start = 1'b0;
  assign bus.md_op    = 2'b00;
  assign bus.in_ready = 1'b1;
`endif
endmodule

// File: tb/tb_alu_control_unit.sv
// Scoreboard bench for alu_control_unit: accepted requests queue their expected
// control word, a negedge monitor pops and compares on every out_valid.
module tb_alu_control_unit;
  localparam int CTRL_W    = 6;
  localparam int MD_CYCLES = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_ctrl_if #(.CTRL_W(CTRL_W)) bus ();

  alu_control_unit #(.CTRL_W(CTRL_W), .MD_CYCLES(MD_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              ill;
  } exp_t;

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] funct;
    logic [1:0] imm;
    logic [3:0] code;
    logic       ill;
  } vec_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one request at the current negedge; queue the expectation if it fires.
  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                       input logic [1:0] imm, input logic [3:0] code, input logic ill,
                       input logic exp_rdy);
    exp_t e;
    bus.in_valid      = v;
    bus.alu_operation = op;
    bus.funct         = f;
    bus.imm_sel       = imm;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (v && bus.in_ready) begin
      e.ctrl = CTRL_W'(code);
      e.ill  = ill;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_md(input string tag, input logic s, input logic b, input logic d);
    chk({tag, ".md_start"}, 32'(bus.md_start), 32'(s));
    chk({tag, ".md_busy"},  32'(bus.md_busy),  32'(b));
    chk({tag, ".md_done"},  32'(bus.md_done),  32'(d));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(1), 32'(0));
      end else begin
        e = sb_q.pop_front();
        chk("alu_control", 32'(bus.alu_control), 32'(e.ctrl));
        chk("illegal", 32'(bus.illegal), 32'(e.ill));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  vec_t vecs[22];

  initial begin
    vecs = '{
      '{2'b10, 6'b100101, 2'b00, 4'b0001, 1'b0},
      '{2'b11, 6'b000000, 2'b10, 4'b0011, 1'b0},
      '{2'b10, 6'b111111, 2'b00, 4'b1111, 1'b1},
      '{2'b00, 6'b111111, 2'b00, 4'b0010, 1'b0},
      '{2'b01, 6'b111111, 2'b11, 4'b0110, 1'b0},
      '{2'b11, 6'b101010, 2'b00, 4'b0000, 1'b0},
      '{2'b11, 6'b101010, 2'b01, 4'b0001, 1'b0},
      '{2'b11, 6'b101010, 2'b11, 4'b0111, 1'b0},
      '{2'b10, 6'b100000, 2'b00, 4'b0010, 1'b0},
      '{2'b10, 6'b100001, 2'b00, 4'b0010, 1'b0},
      '{2'b10, 6'b100010, 2'b00, 4'b0110, 1'b0},
      '{2'b10, 6'b100011, 2'b00, 4'b0110, 1'b0},
      '{2'b10, 6'b100100, 2'b00, 4'b0000, 1'b0},
      '{2'b10, 6'b100110, 2'b00, 4'b0011, 1'b0},
      '{2'b10, 6'b100111, 2'b00, 4'b0100, 1'b0},
      '{2'b10, 6'b101010, 2'b00, 4'b0111, 1'b0},
      '{2'b10, 6'b101011, 2'b00, 4'b0101, 1'b0},
      '{2'b10, 6'b000000, 2'b00, 4'b1000, 1'b0},
      '{2'b10, 6'b000010, 2'b00, 4'b1001, 1'b0},
      '{2'b10, 6'b000011, 2'b00, 4'b1010, 1'b0},
      '{2'b10, 6'b000001, 2'b00, 4'b1111, 1'b1},
      '{2'b10, 6'b101100, 2'b00, 4'b1111, 1'b1}
    };

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.alu_operation = 2'b00; bus.funct = 6'd0; bus.imm_sel = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst.out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst.alu_control", 32'(bus.alu_control), 32'(0));
    chk("rst.illegal", 32'(bus.illegal), 32'(0));
    chk("rst.md_op", 32'(bus.md_op), 32'(0));
    chk_md("rst", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(1'b1, vecs[i].op, vecs[i].funct, vecs[i].imm, vecs[i].code, vecs[i].ill, 1'b1);
    end
    @(negedge clk); idle();
    @(negedge clk);
    chk("idle.out_valid", 32'(bus.out_valid), 32'(0));
    chk("hold.alu_control", 32'(bus.alu_control), 32'(6'b001111));
    chk("hold.illegal", 32'(bus.illegal), 32'(1));

`ifdef ALU_MDU_EN
    // mult accepted, then mflo / add / mflo / mflo against the interlock
    drive(1'b1, 2'b10, 6'b011000, 2'b00, 4'b1110, 1'b0, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk_md($sformatf("mult.c%0d", c), c == 1, c <= 4, c == 4);
      if (c <= 4) chk("mult.md_op", 32'(bus.md_op), 32'(0));
      case (c)
        1: drive(1'b1, 2'b10, 6'b010010, 2'b00, 4'b1101, 1'b0, 1'b0);
        2: drive(1'b1, 2'b00, 6'b100000, 2'b00, 4'b0010, 1'b0, 1'b1);
        3: drive(1'b1, 2'b10, 6'b010010, 2'b00, 4'b1101, 1'b0, 1'b0);
        4: drive(1'b1, 2'b10, 6'b010010, 2'b00, 4'b1101, 1'b0, 1'b1);
        default: idle();
      endcase
    end
    @(negedge clk);
    // back-to-back: multu then divu held, issued in the done cycle
    drive(1'b1, 2'b10, 6'b011001, 2'b00, 4'b1110, 1'b0, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk_md($sformatf("b2b.c%0d", c), c == 1 || c == 5, 1'b1, c == 4);
      chk("b2b.md_op", 32'(bus.md_op), c == 5 ? 32'(3) : 32'(1));
      if (c <= 4) drive(1'b1, 2'b10, 6'b011011, 2'b00, 4'b1110, 1'b0, c == 4);
      else idle();
    end
    repeat (4) @(negedge clk);
    chk_md("b2b.end", 1'b0, 1'b0, 1'b0);
    // reset two cycles into a divu run, with a competing accept
    drive(1'b1, 2'b10, 6'b011011, 2'b00, 4'b1110, 1'b0, 1'b1);
    @(negedge clk); idle();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b1; bus.alu_operation = 2'b00;
    @(negedge clk);
    reset = 1'b0; idle();
    chk_md("rstrun", 1'b0, 1'b0, 1'b0);
    chk("rstrun.md_op", 32'(bus.md_op), 32'(0));
    chk("rstrun.out_valid", 32'(bus.out_valid), 32'(0));
    chk("rstrun.alu_control", 32'(bus.alu_control), 32'(0));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rstrun.no_done", 32'(bus.md_done), 32'(0));
    end
`else
    drive(1'b1, 2'b10, 6'b011010, 2'b00, 4'b1111, 1'b1, 1'b1);
    @(negedge clk);
    chk_md("nomdu.div", 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b10, 6'b010000, 2'b00, 4'b1111, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 2'b10, 6'b010010, 2'b00, 4'b1111, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 2'b10, 6'b011000, 2'b00, 4'b1111, 1'b1, 1'b1);
    @(negedge clk); idle();
    chk_md("nomdu.end", 1'b0, 1'b0, 1'b0);
`endif
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
